// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered occupancy/status flags.
// Define SYNC_FIFO_DBG_EN to enable the sticky dbg_overflow/dbg_underflow flags.
module sync_fifo #(
    parameter int LOG_DEPTH       = 10,
    parameter int WIDTH           = 32,
    parameter int ALMOSTFULL_VAL  = (2**LOG_DEPTH)/2,
    parameter int ALMOSTEMPTY_VAL = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrreq,
    input  logic [WIDTH-1:0]     data,
    output logic                 full,
    output logic                 almost_full,
    input  logic                 rdreq,
    output logic [WIDTH-1:0]     q,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [LOG_DEPTH:0]   usedw,
    output logic                 dbg_overflow,
    output logic                 dbg_underflow
);
    localparam int DEPTH = 2**LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_LVL = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] AF_LVL   = (LOG_DEPTH+1)'(ALMOSTFULL_VAL);
    localparam logic [LOG_DEPTH:0] AE_LVL   = (LOG_DEPTH+1)'(ALMOSTEMPTY_VAL);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   next_count;
    logic                 wr_ok;
    logic                 rd_ok;

    // A full FIFO still accepts a write when a read frees the head slot on the same edge.
    assign wr_ok = wrreq && (!full || rdreq);
    assign rd_ok = rdreq && !empty;

    always_comb begin
        next_count = usedw;
        case ({wr_ok, rd_ok})
            2'b10:   next_count = usedw + 1'b1;
            2'b01:   next_count = usedw - 1'b1;
            default: next_count = usedw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (ALMOSTFULL_VAL == 0);
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            usedw        <= next_count;
            empty        <= (next_count == '0);
            full         <= (next_count == FULL_LVL);
            almost_empty <= (next_count <= AE_LVL);
            almost_full  <= (next_count >= AF_LVL);
        end
    end

    // Storage is never cleared; reset only forgets its contents via the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_ptr] <= data;
    end

    assign q = mem[rd_ptr];

`ifdef SYNC_FIFO_DBG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_overflow  <= 1'b0;
            dbg_underflow <= 1'b0;
        end else begin
            if (wrreq && full && !rdreq) dbg_overflow  <= 1'b1;
            if (rdreq && empty)          dbg_underflow <= 1'b1;
        end
    end
`else
    assign dbg_overflow  = 1'b0;
    assign dbg_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a vector table on a 4-deep instance, hand sequences on an 8-deep one.
module tb_sync_fifo;
`ifdef SYNC_FIFO_DBG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 4-deep instance: almost thresholds at their defaults (AF=2, AE=2)
    logic       a_rst = 1'b1, a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_data = '0, a_q;
    logic       a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
    logic [2:0] a_usedw;

    sync_fifo #(.LOG_DEPTH(2), .WIDTH(8)) dut_a (
        .clk(clk), .rst(a_rst), .wrreq(a_wr), .data(a_data), .full(a_full),
        .almost_full(a_af), .rdreq(a_rd), .q(a_q), .empty(a_empty),
        .almost_empty(a_ae), .usedw(a_usedw), .dbg_overflow(a_ovf),
        .dbg_underflow(a_unf)
    );

    // 8-deep instance with explicit thresholds
    logic       b_rst = 1'b1, b_wr = 1'b0, b_rd = 1'b0;
    logic [7:0] b_data = '0, b_q;
    logic       b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
    logic [3:0] b_usedw;

    sync_fifo #(.LOG_DEPTH(3), .WIDTH(8), .ALMOSTFULL_VAL(6), .ALMOSTEMPTY_VAL(2)) dut_b (
        .clk(clk), .rst(b_rst), .wrreq(b_wr), .data(b_data), .full(b_full),
        .almost_full(b_af), .rdreq(b_rd), .q(b_q), .empty(b_empty),
        .almost_empty(b_ae), .usedw(b_usedw), .dbg_overflow(b_ovf),
        .dbg_underflow(b_unf)
    );

    typedef struct {
        logic       rst, wr, rd;
        logic [7:0] data;
        logic [2:0] usedw;
        logic       empty, full, af, ae, ovf, unf, chk_q;
        logic [7:0] q;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic rst, wr, rd, input logic [7:0] data,
                               input logic [2:0] usedw, input logic empty, full, af, ae,
                               ovf, unf, chk_q, input logic [7:0] q);
        vec_t r;
        r.rst = rst; r.wr = wr; r.rd = rd; r.data = data; r.usedw = usedw;
        r.empty = empty; r.full = full; r.af = af; r.ae = ae;
        r.ovf = ovf; r.unf = unf; r.chk_q = chk_q; r.q = q;
        return r;
    endfunction

    // One edge on instance B; the head word is checked against the scoreboard before a read.
    task automatic b_step(input logic wr, input logic rd, input logic [7:0] d, input logic push);
        @(negedge clk);
        if (rd && exp_q.size() > 0) chk("b_q", b_q, exp_q.pop_front());
        b_wr = wr; b_rd = rd; b_data = d;
        @(posedge clk);
        #1;
        if (push) exp_q.push_back(d);
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rst wr rd data   used emp ful af ae ovf unf cq q
        vecs.push_back(v(1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 8'h55, 1, 0, 0, 0, 1, 0, 0, 1, 8'h55));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 8'h00));
        vecs.push_back(v(1, 1, 1, 8'h77, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 1, 8'h11, 1, 0, 0, 0, 1, 0, 1, 1, 8'h11));
        vecs.push_back(v(1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 8'h0A, 1, 0, 0, 0, 1, 0, 0, 1, 8'h0A));
        vecs.push_back(v(0, 1, 0, 8'h0B, 2, 0, 0, 1, 1, 0, 0, 1, 8'h0A));
        vecs.push_back(v(0, 1, 0, 8'h0C, 3, 0, 0, 1, 0, 0, 0, 1, 8'h0A));
        vecs.push_back(v(0, 1, 0, 8'h0D, 4, 0, 1, 1, 0, 0, 0, 1, 8'h0A));
        vecs.push_back(v(0, 1, 0, 8'h0E, 4, 0, 1, 1, 0, 1, 0, 1, 8'h0A));
        vecs.push_back(v(0, 0, 1, 8'h00, 3, 0, 0, 1, 0, 1, 0, 1, 8'h0B));
        vecs.push_back(v(0, 0, 1, 8'h00, 2, 0, 0, 1, 1, 1, 0, 1, 8'h0C));
        vecs.push_back(v(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 0, 1, 8'h0D));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 1, 0, 0, 8'h00));
        vecs.push_back(v(1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 8'h21, 1, 0, 0, 0, 1, 0, 0, 1, 8'h21));
        vecs.push_back(v(0, 1, 0, 8'h22, 2, 0, 0, 1, 1, 0, 0, 1, 8'h21));
        vecs.push_back(v(0, 1, 0, 8'h23, 3, 0, 0, 1, 0, 0, 0, 1, 8'h21));
        vecs.push_back(v(0, 1, 0, 8'h24, 4, 0, 1, 1, 0, 0, 0, 1, 8'h21));
        vecs.push_back(v(0, 1, 1, 8'h99, 4, 0, 1, 1, 0, 0, 0, 1, 8'h22));
        vecs.push_back(v(0, 0, 1, 8'h00, 3, 0, 0, 1, 0, 0, 0, 1, 8'h23));
        vecs.push_back(v(0, 0, 1, 8'h00, 2, 0, 0, 1, 1, 0, 0, 1, 8'h24));
        vecs.push_back(v(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 8'h99));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 8'h31, 1, 0, 0, 0, 1, 0, 0, 1, 8'h31));
        vecs.push_back(v(0, 1, 1, 8'h32, 1, 0, 0, 0, 1, 0, 0, 1, 8'h32));
        vecs.push_back(v(0, 1, 0, 8'h33, 2, 0, 0, 1, 1, 0, 0, 1, 8'h32));
        vecs.push_back(v(1, 1, 0, 8'h44, 0, 1, 0, 0, 1, 0, 0, 0, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a_rst = vecs[i].rst; a_wr = vecs[i].wr; a_rd = vecs[i].rd; a_data = vecs[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("a_usedw[%0d]", i), a_usedw, vecs[i].usedw);
            chk($sformatf("a_empty[%0d]", i), a_empty, vecs[i].empty);
            chk($sformatf("a_full[%0d]", i), a_full, vecs[i].full);
            chk($sformatf("a_af[%0d]", i), a_af, vecs[i].af);
            chk($sformatf("a_ae[%0d]", i), a_ae, vecs[i].ae);
            chk($sformatf("a_ovf[%0d]", i), a_ovf, vecs[i].ovf & DBG);
            chk($sformatf("a_unf[%0d]", i), a_unf, vecs[i].unf & DBG);
            if (vecs[i].chk_q) chk($sformatf("a_q[%0d]", i), a_q, vecs[i].q);
        end
        @(negedge clk);
        a_rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0;

        // Instance B: reset, then fill 0->8 watching the threshold flags
        @(negedge clk);
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        chk("b_rst_usedw", b_usedw, 0);
        chk("b_rst_empty", b_empty, 1);
        chk("b_rst_ae", b_ae, 1);
        chk("b_rst_af", b_af, 0);
        for (int k = 1; k <= 8; k++) begin
            b_step(1'b1, 1'b0, 8'(k), 1'b1);
            chk($sformatf("b_fill_usedw[%0d]", k), b_usedw, k);
            chk($sformatf("b_fill_ae[%0d]", k), b_ae, (k <= 2));
            chk($sformatf("b_fill_af[%0d]", k), b_af, (k >= 6));
            chk($sformatf("b_fill_full[%0d]", k), b_full, (k == 8));
        end
        for (int k = 0; k < 8; k++) b_step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("b_drain_empty", b_empty, 1);

        // Sustained simultaneous traffic wrapping the pointers several times
        for (int k = 0; k < 3; k++) b_step(1'b1, 1'b0, 8'(8'h40 + k), 1'b1);
        for (int k = 0; k < 20; k++) b_step(1'b1, 1'b1, 8'(8'h50 + k), 1'b1);
        chk("b_wrap_usedw", b_usedw, 3);
        for (int k = 0; k < 3; k++) b_step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("b_wrap_empty", b_empty, 1);

        // Overflow, partial drain to 5, then reset with a concurrent write
        for (int k = 0; k < 8; k++) b_step(1'b1, 1'b0, 8'(8'h60 + k), 1'b1);
        b_step(1'b1, 1'b0, 8'hEE, 1'b0);
        chk("b_ovf_usedw", b_usedw, 8);
        chk("b_ovf_full", b_full, 1);
        chk("b_ovf_flag", b_ovf, DBG);
        for (int k = 0; k < 3; k++) b_step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("b_pre_rst_usedw", b_usedw, 5);
        chk("b_pre_rst_ovf", b_ovf, DBG);
        chk("b_pre_rst_q", b_q, exp_q[0]);
        @(negedge clk);
        b_rst = 1'b1; b_wr = 1'b1; b_data = 8'hAB;
        @(posedge clk);
        #1;
        b_rst = 1'b0; b_wr = 1'b0;
        exp_q.delete();
        chk("b_rst_mid_usedw", b_usedw, 0);
        chk("b_rst_mid_empty", b_empty, 1);
        chk("b_rst_mid_ovf", b_ovf, 0);
        chk("b_rst_mid_full", b_full, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL take parameter LOG_DEPTH, default 10, meaning log2 of the storage depth (DEPTH = 2**LOG_DEPTH words).
REQ-002 The block SHALL take parameter WIDTH, default 32, meaning the data word width in bits.
REQ-003 The block SHALL take parameter ALMOSTFULL_VAL, default (2**LOG_DEPTH)/2, meaning the occupancy at or above which almost_full asserts.
REQ-004 The block SHALL take parameter ALMOSTEMPTY_VAL, default 2, meaning the occupancy at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wrreq  input  1  write request; data is captured when the write is accepted.
REQ-008 data  input  WIDTH  write data.
REQ-009 full  output  1  occupancy == DEPTH.
REQ-010 almost_full  output  1  occupancy >= ALMOSTFULL_VAL.
REQ-011 rdreq  input  1  read acknowledge; pops the word currently on q.
REQ-012 q  output  WIDTH  head word (show-ahead); valid whenever empty is low.
REQ-013 empty  output  1  occupancy == 0.
REQ-014 almost_empty  output  1  occupancy <= ALMOSTEMPTY_VAL.
REQ-015 usedw  output  LOG_DEPTH+1  current occupancy, 0..DEPTH inclusive.
REQ-016 dbg_overflow  output  1  sticky: a write was dropped.
REQ-017 dbg_underflow  output  1  sticky: a read was ignored.

Function
REQ-018 Write accepted = wrreq && (!full || rdreq); read accepted = rdreq && !empty.
REQ-019 Accepted write SHALL store data at the write pointer and advance it modulo DEPTH; accepted read SHALL advance the read pointer modulo DEPTH.
REQ-020 usedw SHALL update on the edge: +1 write only, -1 read only, unchanged for both or neither; never exceeds DEPTH nor drops below 0.
REQ-021 All status outputs (full, empty, almost_*, usedw) SHALL be registered and reflect occupancy after the current edge, i.e. one-cycle latency from the causing request.
REQ-022 Write into empty FIFO at edge N SHALL drive empty low and q = that word in the cycle after edge N.
REQ-023 q SHALL present the oldest stored word combinationally from the read pointer; after an accepted read at edge N, q SHALL show the next word in the cycle after edge N.
REQ-024 q content while empty is high SHALL be don't-care.
REQ-025 At full, wrreq with rdreq SHALL accept both; usedw stays DEPTH, written word lands in the freed slot.
REQ-026 At full, wrreq without rdreq SHALL drop the write with no state change and set dbg_overflow.
REQ-027 At empty, rdreq SHALL be ignored and set dbg_underflow; a simultaneous wrreq SHALL still be accepted (no bypass: word appears next cycle).
REQ-028 Pointers SHALL wrap DEPTH-1 -> 0 with no gap or duplicate word.

Reset
REQ-029 rst high at an edge SHALL clear pointers and usedw to 0, set empty=1, almost_empty=1, full=0, almost_full=0 (unless ALMOSTFULL_VAL==0), dbg_overflow=0, dbg_underflow=0.
REQ-030 rst SHALL override simultaneous wrreq/rdreq; stored words are discarded, storage array need not be cleared.
REQ-031 Reset mid-operation SHALL take effect at the next edge regardless of occupancy.

Configuration
REQ-032 Macro SYNC_FIFO_DBG_EN defined: dbg_overflow/dbg_underflow behave per REQ-026/027, cleared only by rst.
REQ-033 Macro SYNC_FIFO_DBG_EN undefined: dbg_overflow and dbg_underflow SHALL be tied 0 with no debug logic; all other behaviour identical.

Verification
REQ-034 LOG_DEPTH=2: write 0xA,0xB,0xC,0xD -> full=1, usedw=4 one cycle after 4th write; 5th write 0xE -> dropped, dbg_overflow=1; reads return A,B,C,D.
REQ-035 Empty FIFO, wrreq with data=0x55 at edge N -> empty=0, q=0x55, usedw=1 in cycle N+1.
REQ-036 Full (DEPTH=4), simultaneous wrreq(0x99)+rdreq -> usedw stays 4, full stays 1; draining yields remaining 3 old words then 0x99.
REQ-037 Empty FIFO, rdreq+wrreq(0x11) same edge -> dbg_underflow=1, usedw=1, q=0x11 next cycle.
REQ-038 LOG_DEPTH=3, ALMOSTFULL_VAL=6, ALMOSTEMPTY_VAL=2: fill 0->8 -> almost_empty low at usedw=3, almost_full high at usedw=6; 20 write/read cycles across wrap -> data order preserved.
REQ-039 usedw=5 with dbg_overflow=1, assert rst one cycle with wrreq=1 -> next cycle usedw=0, empty=1, dbg_overflow=0.
